// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// a constant helper for sizing the bit counter.
package serial_sub_pkg;

  // Controller states; the spare 2'b11 code is treated as IDLE by the FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1; never returns less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_subtractor_fsub_cell.sv
// One-bit full subtractor: d = x - y - z, with bo the borrow out of this bit.
module fsub_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ z;
  assign bo = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic             borrow_out;
  logic             ovf_q;

  logic cell_d;
  logic cell_bo;
  logic accept;
  logic last_bit;

  // A new request is only taken when no subtraction is in flight.
  assign accept   = start && (state != RUN);
  assign last_bit = (cnt == LAST_BIT);

  fsub_cell u_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .z  (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Controller: sequences IDLE -> RUN (WIDTH bit steps) -> DONE and counts bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          cnt   <= '0;
          state <= accept ? RUN : IDLE;
        end
        RUN: begin
          if (last_bit) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath: load operands on accept, then shift one bit through the cell per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      borrow_out <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (accept) begin
      a_q        <= a;
      b_q        <= b;
      diff_q     <= '0;
      borrow_q   <= bin;
      a_msb      <= a[WIDTH-1];
      b_msb      <= b[WIDTH-1];
      borrow_out <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (state == RUN) begin
      diff_q   <= {cell_d, diff_q[WIDTH-1:1]};
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      borrow_q <= cell_bo;
      if (last_bit) begin
        borrow_out <= cell_bo;
        ovf_q      <= (a_msb != b_msb) && (cell_d != a_msb);
      end
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_out;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases,
// back-to-back starts, mid-run reset and randomized operands vs. a model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for diff/borrow and signed for ovf.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    int r;
    int sa;
    int sb;
    int sr;
    r  = int'(av) - int'(bv) - int'(binv);
    d  = W'(r);
    bo = (r < 0);
    sa = av[W-1] ? int'(av) - (1 << W) : int'(av);
    sb = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
    sr = sa - sb - int'(binv);
    ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endfunction

  // Present operands with a one-cycle start pulse, then scramble the inputs.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                               input string tag);
    @(negedge clk);
    a     = av;
    b     = bv;
    bin   = binv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    a   = W'($urandom);
    b   = W'($urandom);
    bin = 1'($urandom);
  endtask

  // Count negedges until done rises, giving up after a bounded budget.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full single operation: accept, latency, results against model, done pulse width.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                        input string tag);
    int           lat;
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    model(av, bv, binv, ed, eb, eo);
    applyStimulus(av, bv, binv, tag);
    wait_done(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(W));
    checkOutput({tag, "_diff"}, 32'(diff), 32'(ed));
    checkOutput({tag, "_borrow"}, 32'(borrow), 32'(eb));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    checkOutput({tag, "_hold"}, 32'(diff), 32'(ed));
  endtask

  // Directed sequence followed by randomized operands.
  initial begin
    int lat;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    bin      = 1'b0;

    #12;
    checkOutput("reset_outs", {21'd0, busy, done, diff, borrow, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h35, 8'h12, 1'b0, "p1");
    checkOutput("p1_const", {22'd0, ovf, borrow, diff}, {22'd0, 1'b0, 1'b0, 8'h23});
    run_op(8'h12, 8'h35, 1'b0, "p2");
    checkOutput("p2_const", {22'd0, ovf, borrow, diff}, {22'd0, 1'b0, 1'b1, 8'hDD});
    run_op(8'h80, 8'h01, 1'b0, "p3");
    checkOutput("p3_const", {22'd0, ovf, borrow, diff}, {22'd0, 1'b1, 1'b0, 8'h7F});
    run_op(8'h10, 8'h0F, 1'b1, "p4");
    checkOutput("p4_const", {22'd0, borrow, diff}, {22'd0, 1'b0, 8'h00});
    run_op(8'h00, 8'h00, 1'b1, "p5");
    checkOutput("p5_const", {22'd0, borrow, diff}, {22'd0, 1'b1, 8'hFF});
    run_op(8'h66, 8'h66, 1'b0, "p6");
    checkOutput("p6_const", {22'd0, borrow, diff}, {22'd0, 1'b0, 8'h00});

    // Start held high: mid-run operands ignored, second set taken in DONE cycle.
    @(negedge clk);
    a     = 8'h35;
    b     = 8'h12;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checkOutput("b2b_busy1", 32'(busy), 32'd1);
    a   = 8'hAA;
    b   = 8'h55;
    bin = 1'b1;
    wait_done(lat);
    checkOutput("b2b_lat1", 32'(lat), 32'(W));
    checkOutput("b2b_res1", {22'd0, ovf, borrow, diff}, {22'd0, 1'b0, 1'b0, 8'h23});
    a   = 8'h80;
    b   = 8'h01;
    bin = 1'b0;
    @(negedge clk);
    checkOutput("b2b_busy2", {30'd0, busy, done}, 32'd2);
    a   = 8'hC4;
    b   = 8'h3B;
    bin = 1'b1;
    wait_done(lat);
    checkOutput("b2b_period", 32'(lat + 1), 32'(W + 1));
    checkOutput("b2b_res2", {22'd0, ovf, borrow, diff}, {22'd0, 1'b1, 1'b0, 8'h7F});
    start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_idle", {30'd0, busy, done}, 32'd0);

    // Reset in the middle of a run aborts it with no done pulse.
    applyStimulus(8'hC3, 8'h3C, 1'b0, "rst_op");
    repeat (3) @(negedge clk);
    checkOutput("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_outs", {21'd0, busy, done, diff, borrow, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checkOutput("rst_no_done", 32'(seen), 32'd0);
    run_op(8'h5A, 8'h21, 1'b1, "post_rst");

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
